// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: two-entry elastic skid buffer between pipeline stages; define PIPE_STAGE_BUF_BUBBLE_EN to force BUBBLE onto out_data while empty
module pipe_stage_buf #(
    parameter int DATA_W = 68,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              acc, con;

    assign acc       = in_valid & in_ready & ~flush;
    assign con       = out_valid & out_ready;
    assign occupancy = state;

    // next occupancy from the two handshakes, flush overriding everything
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   state_nxt = acc ? ONE : EMPTY;
            ONE:     state_nxt = (acc & ~con) ? FULL : (con & ~acc) ? EMPTY : ONE;
            FULL:    state_nxt = con ? ONE : FULL;
            default: state_nxt = EMPTY;
        endcase
        if (flush)
            state_nxt = EMPTY;
    end

    // state and handshake flags registered from the next state so they never depend combinationally on inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= state_nxt != FULL;
            out_valid <= state_nxt != EMPTY;
        end
    end

    // payload slots; flush freezes them so the old head stays visible in the non-bubble build
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= BUBBLE;
            skid_q <= {DATA_W{1'b0}};
        end else if (!flush) begin
            if (state == FULL && con)
                main_q <= skid_q;
            else if (acc && (state == EMPTY || con))
                main_q <= in_data;
            if (state == ONE && acc && !con)
                skid_q <= in_data;
        end
    end

`ifdef PIPE_STAGE_BUF_BUBBLE_EN
    assign out_data = out_valid ? main_q : BUBBLE;
`else
    assign out_data = main_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed and random checks of pipe_stage_buf against a queue model
module tb_pipe_stage_buf;
    localparam int W = 68;

    logic         clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int cmpd = 0, errs = 0;
    bit chk_en = 0;

    pipe_stage_buf #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // behavioural model: FIFO contents plus the last head value seen
    logic [W-1:0] q[$];
    bit           rdy_en = 0;
    logic [W-1:0] last_head = '0;
    bit           m_acc, m_con;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            rdy_en = 0;
            last_head = '0;
        end else begin
            m_acc = in_valid && rdy_en && q.size() < 2 && !flush;
            m_con = q.size() > 0 && out_ready;
            if (m_con) void'(q.pop_front());
            if (m_acc) q.push_back(in_data);
            if (flush) q.delete();
            rdy_en = 1;
            if (q.size() > 0) last_head = q[0];
        end
    end

    function automatic logic [W-1:0] exp_data();
        if (q.size() > 0) return q[0];
`ifdef PIPE_STAGE_BUF_BUBBLE_EN
        return '0;
`else
        return last_head;
`endif
    endfunction

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        cmpd++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("in_ready", W'(in_ready), W'(rdy_en && q.size() < 2));
            cmp("out_valid", W'(out_valid), W'(q.size() > 0));
            cmp("occupancy", W'(occupancy), W'(q.size()));
            cmp("out_data", out_data, exp_data());
        end
    end

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        in_valid = v; in_data = d; out_ready = r; flush = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [W-1:0] bub;
    logic [W-1:0] rd;

    initial begin
`ifdef PIPE_STAGE_BUF_BUBBLE_EN
        bub = '0;
`else
        bub = 'h5A1;
`endif
        #2 rst = 0;
        chk_en = 1;
        repeat (2) @(negedge clk);
        cmp("rst_in_ready", W'(in_ready), '0);
        rst = 1;
        cyc(0, '0, 0, 0);
        cmp("rel_in_ready", W'(in_ready), 1);
        cyc(1, 'h1234, 0, 0);
        cmp("first_valid", W'(out_valid), 1);
        cmp("first_data", out_data, 'h1234);

        for (int i = 0; i < 10; i++) begin
            cyc(1, W'('hA0 + i), 1, 0);
            cmp("stream_data", out_data, W'('hA0 + i));
            cmp("stream_ready", W'(in_ready), 1);
        end
        cyc(0, '0, 1, 0);
        cmp("drained", W'(out_valid), 0);

        cyc(1, 'hB0, 0, 0);
        cmp("bp_occ0", W'(occupancy), 1);
        cyc(1, 'hB1, 0, 0);
        cmp("bp_occ1", W'(occupancy), 2);
        cmp("bp_ready", W'(in_ready), 0);
        cyc(1, 'hB2, 0, 0);
        cmp("bp_occ2", W'(occupancy), 2);
        cmp("bp_head", out_data, 'hB0);
        cyc(1, 'hB2, 1, 0);
        cmp("bp_rel0", out_data, 'hB1);
        cyc(1, 'hB2, 1, 0);
        cmp("bp_rel1", out_data, 'hB2);
        cyc(0, '0, 1, 0);
        cmp("bp_empty", W'(occupancy), 0);

        cyc(1, 'h5A1, 0, 0);
        cyc(1, 'h5A2, 0, 0);
        cyc(1, 'hC, 0, 1);
        cmp("fl_occ", W'(occupancy), 0);
        cmp("fl_valid", W'(out_valid), 0);
        cmp("fl_ready", W'(in_ready), 1);
        cmp("fl_data", out_data, bub);
        cyc(0, '0, 1, 0);
        cmp("fl_noC", W'(out_valid), 0);

        cyc(1, 'hD, 0, 0);
        cyc(1, 'hE, 0, 0);
        cmp("fd_head", out_data, 'hD);
        cyc(0, '0, 1, 1);
        cmp("fd_occ", W'(occupancy), 0);
        cyc(0, '0, 1, 0);
        cmp("fd_noE", W'(out_valid), 0);

        cyc(1, '1, 0, 0);
        cyc(1, 'h77, 0, 0);
        cmp("ones_head", out_data, '1);
        #2 rst = 0;
        #1;
        cmp("ar_valid", W'(out_valid), 0);
        cmp("ar_occ", W'(occupancy), 0);
        cmp("ar_data", out_data, '0);
        cmp("ar_ready", W'(in_ready), 0);
        @(negedge clk);
        rst = 1;
        cyc(0, '0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            rd = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 9) == 0) rd = '1;
            cyc($urandom_range(0, 3) != 0, rd, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpd, errs);
        $finish;
    end
endmodule
